// File: rtl/nibble_pkg.sv
// Shared types and widths for the nibble assembler and the downstream swap stage.
package nibble_pkg;

   localparam int NIBBLE_W = 4;
   localparam int BYTE_W   = 8;

   typedef enum logic {
      ASM_IDLE,
      ASM_HALF
   } asm_state_t;

endpackage

// File: rtl/nibble_fifo.sv
// First-word fall-through FIFO: the head entry is read straight from registered storage.
module nibble_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           pop_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     fill
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int FILL_W = PTR_W + 1;

   logic [WIDTH-1:0]  mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [FILL_W-1:0] fill_q;
   logic              do_push;
   logic              do_pop;

   assign full     = (fill_q == FILL_W'(DEPTH));
   assign empty    = (fill_q == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];
   assign fill     = fill_q;

   // NOTE: storage is reset too, so the head entry reads 8'h00 straight out of reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         fill_q <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every register sampling pre-edge values.
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   fill_q <= fill_q + 1'b1;
            2'b01:   fill_q <= fill_q - 1'b1;
            default: fill_q <= fill_q;
         endcase
      end
   end

endmodule

// File: rtl/nibble_pair_assembler.sv
// Pairs incoming nibbles into bytes {high, low}, buffers them in a FIFO and
// drops a half-received byte after an idle timeout.
module nibble_pair_assembler
   import nibble_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 255
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NIBBLE_W-1:0]      nib_in,
   input  logic                     nib_valid,
   output logic                     nib_ready,
   output logic [BYTE_W-1:0]        byte_out,
   output logic                     byte_valid,
   input  logic                     byte_ready,
   output logic                     err_timeout,
   output logic [$clog2(DEPTH):0]   fill
);

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   asm_state_t          state, state_nxt;
   logic [NIBBLE_W-1:0] high_q, high_nxt;
   logic [7:0]          cnt_q, cnt_nxt;
   logic                err_nxt;
   logic                nib_accept;
   logic                push;
   logic                full;
   logic                empty;

   // Ready depends only on registered state, never on byte_ready.
   assign nib_ready  = (state == ASM_IDLE) || !full;
   assign nib_accept = nib_valid && nib_ready;
   assign byte_valid = !empty;

   // NOTE: every output of this block gets a default first, so no latch is inferred.
   always_comb begin
      state_nxt = state;
      high_nxt  = high_q;
      cnt_nxt   = cnt_q;
      err_nxt   = 1'b0;
      push      = 1'b0;
      case (state)
         ASM_IDLE: begin
            if (nib_accept) begin
               high_nxt  = nib_in;
               cnt_nxt   = '0;
               state_nxt = ASM_HALF;
            end
         end
         ASM_HALF: begin
            if (nib_accept) begin
               push      = 1'b1;
               state_nxt = ASM_IDLE;
            end else if (cnt_q == TO_LAST) begin
               high_nxt  = '0;
               err_nxt   = 1'b1;
               state_nxt = ASM_IDLE;
            end else begin
               cnt_nxt = cnt_q + 8'd1;
            end
         end
         default: state_nxt = ASM_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ASM_IDLE;
         high_q      <= '0;
         cnt_q       <= '0;
         err_timeout <= 1'b0;
      end else begin
         state       <= state_nxt;
         high_q      <= high_nxt;
         cnt_q       <= cnt_nxt;
         err_timeout <= err_nxt;
      end
   end

   nibble_fifo #(
      .WIDTH (BYTE_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data ({high_q, nib_in}),
      .pop       (byte_ready),
      .pop_data  (byte_out),
      .full      (full),
      .empty     (empty),
      .fill      (fill)
   );

endmodule

// File: tb/tb_nibble_pair_assembler.sv
// Directed bench for nibble_pair_assembler: pairing, timeout, backpressure and reset.
module tb_nibble_pair_assembler;

   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 255;
   localparam int FILL_W  = $clog2(DEPTH) + 1;

   logic              clk = 1'b0;
   logic              rst;
   logic [3:0]        nib_in;
   logic              nib_valid;
   logic              nib_ready;
   logic [7:0]        byte_out;
   logic              byte_valid;
   logic              byte_ready;
   logic              err_timeout;
   logic [FILL_W-1:0] fill;

   int         n_checks   = 0;
   int         n_fail     = 0;
   int         err_cnt    = 0;
   int         stall_viol = 0;
   int         max_fill   = 0;
   logic [7:0] got_q [$];
   logic       stalled_prev = 1'b0;
   logic [7:0] out_prev = 8'h00;

   always #5 clk = ~clk;

   nibble_pair_assembler #(
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .nib_in      (nib_in),
      .nib_valid   (nib_valid),
      .nib_ready   (nib_ready),
      .byte_out    (byte_out),
      .byte_valid  (byte_valid),
      .byte_ready  (byte_ready),
      .err_timeout (err_timeout),
      .fill        (fill)
   );

   // Observes the output side mid-cycle, where inputs and outputs are both settled.
   always @(negedge clk) begin
      if (rst) begin
         stalled_prev = 1'b0;
      end else begin
         if (err_timeout) err_cnt++;
         if (int'(fill) > max_fill) max_fill = int'(fill);
         if (stalled_prev && byte_valid && (byte_out !== out_prev)) stall_viol++;
         if (byte_valid && byte_ready) got_q.push_back(byte_out);
         stalled_prev = byte_valid && !byte_ready;
         out_prev     = byte_out;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_nibble(input logic [3:0] n);
      int k = 0;
      nib_in    = n;
      nib_valid = 1'b1;
      while (!nib_ready && k < 600) begin
         tick();
         k++;
      end
      n_checks++;
      if (!nib_ready) begin
         n_fail++;
         $display("FAIL send_nibble_bound: nib_ready stayed %b, required 1", nib_ready);
      end else begin
         tick();
      end
      nib_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int k = 0;
      while (byte_valid && k < 200) begin
         tick();
         k++;
      end
      n_checks++;
      if (byte_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL drain_bound: byte_valid=%b, required 0", byte_valid);
      end
   endtask

   task automatic test_reset();
      rst        = 1'b1;
      nib_in     = 4'h0;
      nib_valid  = 1'b0;
      byte_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (nib_ready !== 1'b1) begin n_fail++; $display("FAIL reset_nib_ready: got %b expected 1", nib_ready); end
      n_checks++;
      if (byte_valid !== 1'b0) begin n_fail++; $display("FAIL reset_byte_valid: got %b expected 0", byte_valid); end
      n_checks++;
      if (byte_out !== 8'h00) begin n_fail++; $display("FAIL reset_byte_out: got %h expected 00", byte_out); end
      n_checks++;
      if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err_timeout); end
      n_checks++;
      if (fill !== '0) begin n_fail++; $display("FAIL reset_fill: got %0d expected 0", fill); end
      @(negedge clk);
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic_pairs();
      logic [7:0] exp_q [$];
      int         err_base;
      exp_q    = '{8'hAB, 8'hCD};
      err_base = err_cnt;
      got_q.delete();
      byte_ready = 1'b1;
      send_nibble(4'hA);
      send_nibble(4'hB);
      send_nibble(4'hC);
      send_nibble(4'hD);
      wait_drain();
      tick();
      n_checks++;
      if (got_q.size() !== exp_q.size()) begin
         n_fail++; $display("FAIL basic_count: got %0d bytes expected %0d", got_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL basic_byte%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
         end
      end
      n_checks++;
      if (fill !== '0) begin n_fail++; $display("FAIL basic_fill: got %0d expected 0", fill); end
      n_checks++;
      if (err_cnt !== err_base) begin n_fail++; $display("FAIL basic_err: got %0d pulses expected 0", err_cnt - err_base); end
   endtask

   task automatic test_timeout();
      int err_base;
      err_base = err_cnt;
      got_q.delete();
      send_nibble(4'h5);
      repeat (TIMEOUT - 1) tick();
      n_checks++;
      if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_early: got %b expected 0", err_timeout); end
      tick();
      n_checks++;
      if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_pulse: got %b expected 1", err_timeout); end
      n_checks++;
      if (nib_ready !== 1'b1) begin n_fail++; $display("FAIL timeout_idle_ready: got %b expected 1", nib_ready); end
      tick();
      n_checks++;
      if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_one_cycle: got %b expected 0", err_timeout); end
      n_checks++;
      if (err_cnt - err_base !== 1) begin n_fail++; $display("FAIL timeout_count: got %0d pulses expected 1", err_cnt - err_base); end
      send_nibble(4'h1);
      send_nibble(4'h2);
      wait_drain();
      tick();
      n_checks++;
      if (got_q.size() !== 1) begin
         n_fail++; $display("FAIL timeout_after_count: got %0d bytes expected 1", got_q.size());
      end else begin
         n_checks++;
         if (got_q[0] !== 8'h12) begin n_fail++; $display("FAIL timeout_after_byte: got %h expected 12", got_q[0]); end
      end
   endtask

   task automatic test_expiry_accept();
      int err_base;
      err_base = err_cnt;
      got_q.delete();
      send_nibble(4'h7);
      repeat (TIMEOUT - 1) tick();
      send_nibble(4'h8);
      n_checks++;
      if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL expiry_err: got %b expected 0", err_timeout); end
      wait_drain();
      repeat (2) tick();
      n_checks++;
      if (err_cnt !== err_base) begin n_fail++; $display("FAIL expiry_err_count: got %0d pulses expected 0", err_cnt - err_base); end
      n_checks++;
      if (got_q.size() !== 1) begin
         n_fail++; $display("FAIL expiry_count: got %0d bytes expected 1", got_q.size());
      end else begin
         n_checks++;
         if (got_q[0] !== 8'h78) begin n_fail++; $display("FAIL expiry_byte: got %h expected 78", got_q[0]); end
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] exp_q [$];
      exp_q = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
      got_q.delete();
      max_fill   = 0;
      byte_ready = 1'b0;
      for (int i = 1; i <= 9; i++) send_nibble(4'(i));
      n_checks++;
      if (fill !== FILL_W'(DEPTH)) begin n_fail++; $display("FAIL bp_fill_full: got %0d expected %0d", fill, DEPTH); end
      n_checks++;
      if (nib_ready !== 1'b0) begin n_fail++; $display("FAIL bp_nib_ready: got %b expected 0", nib_ready); end
      n_checks++;
      if (byte_out !== 8'h12) begin n_fail++; $display("FAIL bp_head: got %h expected 12", byte_out); end
      byte_ready = 1'b1;
      send_nibble(4'hA);
      wait_drain();
      tick();
      n_checks++;
      if (max_fill !== DEPTH) begin n_fail++; $display("FAIL bp_max_fill: got %0d expected %0d", max_fill, DEPTH); end
      n_checks++;
      if (got_q.size() !== exp_q.size()) begin
         n_fail++; $display("FAIL bp_count: got %0d bytes expected %0d", got_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_byte%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_q [$];
      exp_q = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
      got_q.delete();
      max_fill   = 0;
      stall_viol = 0;
      byte_ready = 1'b1;
      fork
         begin
            for (int i = 0; i < 16; i++) send_nibble(4'(i));
         end
         begin
            repeat (48) begin
               tick();
               byte_ready = ~byte_ready;
            end
         end
      join
      byte_ready = 1'b1;
      wait_drain();
      tick();
      n_checks++;
      if (max_fill > DEPTH) begin n_fail++; $display("FAIL b2b_fill_range: got %0d expected <= %0d", max_fill, DEPTH); end
      n_checks++;
      if (stall_viol !== 0) begin n_fail++; $display("FAIL b2b_stall_stable: got %0d changes expected 0", stall_viol); end
      n_checks++;
      if (got_q.size() !== exp_q.size()) begin
         n_fail++; $display("FAIL b2b_count: got %0d bytes expected %0d", got_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_byte%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
         end
      end
   endtask

   task automatic test_mid_reset();
      int err_base;
      err_base = err_cnt;
      got_q.delete();
      byte_ready = 1'b0;
      send_nibble(4'h1);
      send_nibble(4'h2);
      send_nibble(4'h3);
      send_nibble(4'h4);
      send_nibble(4'h5);
      n_checks++;
      if (fill !== FILL_W'(2)) begin n_fail++; $display("FAIL mr_fill_before: got %0d expected 2", fill); end
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if (byte_valid !== 1'b0) begin n_fail++; $display("FAIL mr_byte_valid: got %b expected 0", byte_valid); end
      n_checks++;
      if (fill !== '0) begin n_fail++; $display("FAIL mr_fill: got %0d expected 0", fill); end
      n_checks++;
      if (nib_ready !== 1'b1) begin n_fail++; $display("FAIL mr_nib_ready: got %b expected 1", nib_ready); end
      n_checks++;
      if (byte_out !== 8'h00) begin n_fail++; $display("FAIL mr_byte_out: got %h expected 00", byte_out); end
      @(negedge clk);
      rst = 1'b0;
      tick();
      byte_ready = 1'b1;
      send_nibble(4'h6);
      send_nibble(4'h7);
      wait_drain();
      tick();
      n_checks++;
      if (err_cnt !== err_base) begin n_fail++; $display("FAIL mr_err: got %0d pulses expected 0", err_cnt - err_base); end
      n_checks++;
      if (got_q.size() !== 1) begin
         n_fail++; $display("FAIL mr_count: got %0d bytes expected 1", got_q.size());
      end else begin
         n_checks++;
         if (got_q[0] !== 8'h67) begin n_fail++; $display("FAIL mr_byte: got %h expected 67", got_q[0]); end
      end
   endtask

   initial begin
      test_reset();
      test_basic_pairs();
      test_timeout();
      test_expiry_accept();
      test_backpressure();
      test_back_to_back();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
